// File: rtl/spi_byte_arbiter.sv
// spi_byte_arbiter: round-robin arbiter that shares one SPI byte engine among
// NUM_REQ requesters. An owner keeps the grant for a whole transaction
// (until a byte flagged req_last completes), so multi-byte commands stay atomic.
module spi_byte_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [7:0]           rsp_data,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 eng_start,
    output logic [7:0]           eng_data,
    input  logic                 eng_busy,
    input  logic [7:0]           eng_rx
);

    localparam int          IW        = (NUM_REQ > 2) ? 2 : 1;
    localparam int unsigned NUM_REQ_U = NUM_REQ;

    typedef enum logic [1:0] {
        ARB,
        ISSUE,
        WAIT
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic               last_q, last_d;
    logic [NUM_REQ-1:0] grant_d;
    logic [NUM_REQ-1:0] req_ready_d;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [7:0]         rsp_data_d;

    logic [IW-1:0]      sel;
    logic               sel_found;
    int unsigned        idx;
    int unsigned        owner_i;

    assign owner_i = 32'(owner_q);

    // Round-robin search: first asserted requester at or above rr_ptr, wrapping.
    always_comb begin
        sel       = rr_ptr_q;
        sel_found = 1'b0;
        idx       = 0;
        for (int unsigned i = 0; i < NUM_REQ_U; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ_U;
            if (!sel_found && req_valid[idx]) begin
                sel       = IW'(idx);
                sel_found = 1'b1;
            end
        end
    end

    // Engine-facing outputs follow the current owner only while issuing.
    always_comb begin
        eng_start = (state_q == ISSUE) && req_valid[owner_q];
        eng_data  = req_data[8*owner_i +: 8];
    end

    // Next-state and next-output decode.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        last_d      = last_q;
        grant_d     = grant;
        rsp_data_d  = rsp_data;
        req_ready_d = '0;
        rsp_valid_d = '0;
        case (state_q)
            ARB: begin
                if (sel_found) begin
                    grant_d      = '0;
                    grant_d[sel] = 1'b1;
                    owner_d      = sel;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (eng_busy) begin
                    req_ready_d = grant;
                    last_d      = req_last[owner_q];
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (!eng_busy) begin
                    rsp_data_d  = eng_rx;
                    rsp_valid_d = grant;
                    if (last_q) begin
                        state_d  = ARB;
                        grant_d  = '0;
                        rr_ptr_d = (owner_i == NUM_REQ_U - 1) ? '0 : owner_q + 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            default: begin
                state_d = ARB;
                grant_d = '0;
            end
        endcase
    end

    // State and registered outputs; reset wins over any in-flight byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ARB;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            last_q    <= 1'b0;
            grant     <= '0;
            req_ready <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_ptr_q  <= rr_ptr_d;
            last_q    <= last_d;
            grant     <= grant_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_spi_byte_arbiter.sv
// Directed bench for spi_byte_arbiter with two queue-driven requesters and a
// behavioural byte engine whose RX byte is TX ^ 8'h99.
module tb_spi_byte_arbiter;

    typedef struct {
        logic [1:0] mask;
        logic [7:0] d0;
        logic [7:0] d1;
        int         n_ord;
        int         ord0;
        int         ord1;
        logic [7:0] rx0;
        logic [7:0] rx1;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_valid = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  req_last = '0;
    logic [1:0]  req_ready, rsp_valid, grant;
    logic [7:0]  rsp_data, eng_data;
    logic        eng_start;
    logic        eng_busy = 1'b0;
    logic [7:0]  eng_rx = '0;

    spi_byte_arbiter #(.NUM_REQ(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .grant(grant), .eng_start(eng_start), .eng_data(eng_data),
        .eng_busy(eng_busy), .eng_rx(eng_rx)
    );

    always #5 clk = ~clk;

    int total = 0, passes = 0;
    // requester queues
    logic [7:0] qb[2][8];
    logic       ql[2][8];
    int         qn[2], qp[2];
    logic       en[2];
    // scoreboard / history
    logic       pending;
    int         pend_owner;
    logic [7:0] pend_byte;
    int         ord[16];
    int         nord;
    int         rsp_own[16];
    logic [7:0] rsp_dat[16];
    int         nrsp;
    int         nready[2];
    int         start_cnt, eng_accepts;
    logic [1:0] prev_grant;
    // engine model
    int         es, pend, bcnt, eng_delay, busy_len;
    logic [7:0] tx;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            passes++;
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < 2; r++) begin
            req_valid[r]        = en[r] && (qp[r] < qn[r]);
            req_data[8*r +: 8]  = (qp[r] < qn[r]) ? qb[r][qp[r]] : 8'h00;
            req_last[r]         = (qp[r] < qn[r]) ? ql[r][qp[r]] : 1'b0;
        end
    endtask

    task automatic clear_hist();
        nord = 0; nrsp = 0; nready[0] = 0; nready[1] = 0;
        start_cnt = 0; eng_accepts = 0;
    endtask

    task automatic cycle();
        int r;
        @(negedge clk);
        chk("invariant", {31'd0, $onehot0(req_ready) && $onehot0(rsp_valid) &&
            $onehot0(grant) && !(grant == 2'b00 && eng_start)}, 32'd1);
        if (|rsp_valid) begin
            r = rsp_valid[1] ? 1 : 0;
            chk("rsp_expected", {31'd0, pending}, 32'd1);
            chk("rsp_owner", {30'd0, rsp_valid}, {30'd0, 2'b01 << pend_owner});
            chk("rsp_data", {24'd0, rsp_data}, {24'd0, pend_byte ^ 8'h99});
            rsp_own[nrsp] = r; rsp_dat[nrsp] = rsp_data; nrsp++;
            pending = 1'b0;
        end
        if (|req_ready) begin
            r = req_ready[1] ? 1 : 0;
            chk("ready_order", {31'd0, !pending && (qp[r] < qn[r])}, 32'd1);
            pending = 1'b1; pend_owner = r; pend_byte = qb[r][qp[r]];
            qp[r]++; nready[r]++;
        end
        if (grant != 2'b00 && prev_grant == 2'b00) begin
            ord[nord] = grant[1] ? 1 : 0; nord++;
        end
        prev_grant = grant;
        if (grant != 2'b00 && eng_start) start_cnt++;
        case (es)
            0: if (eng_start && !reset) begin
                tx = eng_data; pend = eng_delay; es = 1; eng_accepts++;
            end
            1: if (pend == 0) begin eng_busy = 1'b1; bcnt = busy_len; es = 2; end
               else pend--;
            default: if (bcnt == 0) begin eng_busy = 1'b0; eng_rx = tx ^ 8'h99; es = 0; end
               else bcnt--;
        endcase
        drive_reqs();
    endtask

    task automatic do_reset();
        reset = 1'b1; es = 0; eng_busy = 1'b0; eng_rx = '0;
        eng_delay = 0; busy_len = 2;
        for (int r = 0; r < 2; r++) begin qn[r] = 0; qp[r] = 0; en[r] = 1'b1; end
        pending = 1'b0; prev_grant = '0;
        drive_reqs();
        cycle(); cycle();
        reset = 1'b0;
        clear_hist();
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        qb[r][qn[r]] = b; ql[r][qn[r]] = l; qn[r]++;
    endtask

    task automatic run_until_idle(input string name, input int budget);
        int k = 0;
        drive_reqs();
        while (!(qp[0] == qn[0] && qp[1] == qn[1] && grant == 2'b00 && es == 0 && !pending)
               && k < budget) begin
            cycle(); k++;
        end
        chk({name, "_timeout"}, {31'd0, k < budget}, 32'd1);
    endtask

    vec_t vec[7];
    int   bad;

    initial begin
        vec[0] = '{2'b01, 8'hA5, 8'h00, 1, 0, 0, 8'h3C, 8'h00};
        vec[1] = '{2'b11, 8'h12, 8'h34, 2, 1, 0, 8'hAD, 8'h8B};
        vec[2] = '{2'b10, 8'h00, 8'hF0, 1, 1, 0, 8'h69, 8'h00};
        vec[3] = '{2'b11, 8'h00, 8'hFF, 2, 0, 1, 8'h99, 8'h66};
        vec[4] = '{2'b10, 8'h00, 8'hC3, 1, 1, 0, 8'h5A, 8'h00};
        vec[5] = '{2'b01, 8'h5A, 8'h00, 1, 0, 0, 8'hC3, 8'h00};
        vec[6] = '{2'b11, 8'h81, 8'h7E, 2, 1, 0, 8'hE7, 8'h18};

        // reset state
        do_reset();
        chk("rst_grant", {30'd0, grant}, 32'd0);
        chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("rst_eng_start", {31'd0, eng_start}, 32'd0);

        // table of single-byte rounds, rr_ptr carried from row to row
        for (int i = 0; i < 7; i++) begin
            clear_hist();
            if (vec[i].mask[0]) push(0, vec[i].d0, 1'b1);
            if (vec[i].mask[1]) push(1, vec[i].d1, 1'b1);
            run_until_idle("vec", 200);
            chk($sformatf("vec%0d_nord", i), nord, vec[i].n_ord);
            chk($sformatf("vec%0d_ord0", i), ord[0], vec[i].ord0);
            chk($sformatf("vec%0d_rx0", i), {24'd0, rsp_dat[0]}, {24'd0, vec[i].rx0});
            chk($sformatf("vec%0d_nready", i), nready[0] + nready[1], vec[i].n_ord);
            if (vec[i].n_ord == 2) begin
                chk($sformatf("vec%0d_ord1", i), ord[1], vec[i].ord1);
                chk($sformatf("vec%0d_rx1", i), {24'd0, rsp_dat[1]}, {24'd0, vec[i].rx1});
            end
        end

        // simultaneous after reset: req0, req1, then req0 again loses to req1 order
        do_reset();
        push(0, 8'h11, 1'b1); push(0, 8'h22, 1'b1); push(1, 8'h33, 1'b1);
        run_until_idle("rr2", 300);
        chk("rr2_nord", nord, 3);
        chk("rr2_seq", {ord[0][7:0], ord[1][7:0], ord[2][7:0]}, 32'h000100);

        // locked three-byte transaction with req1 waiting throughout
        do_reset();
        push(0, 8'h9F, 1'b0); push(0, 8'h00, 1'b0); push(0, 8'h00, 1'b1);
        push(1, 8'h77, 1'b1);
        run_until_idle("lock", 300);
        chk("lock_nord", nord, 2);
        chk("lock_ord", {ord[0][7:0], ord[1][7:0]}, 32'h0001);
        chk("lock_rsp_owners", {rsp_own[0][7:0], rsp_own[1][7:0], rsp_own[2][7:0], rsp_own[3][7:0]},
            32'h00000001);

        // stall: owner drops req_valid for 20 cycles between bytes
        do_reset();
        push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b1); push(1, 8'hB1, 1'b1);
        drive_reqs();
        for (int k = 0; k < 50 && nready[0] == 0; k++) cycle();
        chk("stall_first_ready", nready[0], 1);
        en[0] = 1'b0; drive_reqs();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (grant != 2'b01 || eng_start) bad++;
        end
        chk("stall_hold", bad, 0);
        chk("stall_rsp_seen", nrsp, 1);
        en[0] = 1'b1;
        run_until_idle("stall", 300);
        chk("stall_ord", {nord[7:0], ord[0][7:0], ord[1][7:0]}, 32'h020001);

        // reset while a byte is in flight
        do_reset();
        busy_len = 8;
        push(0, 8'hC5, 1'b1); push(0, 8'hD2, 1'b1);
        drive_reqs();
        for (int k = 0; k < 100 && nready[0] < 2; k++) cycle();
        chk("mid_second_ready", nready[0], 2);
        chk("mid_prev_rsp", {24'd0, rsp_data}, 32'h5C);
        reset = 1'b1;
        cycle();
        chk("mid_grant", {30'd0, grant}, 32'd0);
        chk("mid_req_ready", {30'd0, req_ready}, 32'd0);
        chk("mid_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        chk("mid_rsp_data", {24'd0, rsp_data}, 32'd0);
        chk("mid_eng_start", {31'd0, eng_start}, 32'd0);
        reset = 1'b0;
        pending = 1'b0; qp[0] = qn[0];
        clear_hist();
        for (int k = 0; k < 30 && es != 0; k++) cycle();
        for (int k = 0; k < 3; k++) cycle();
        chk("mid_abandoned_rsp", nrsp, 0);
        busy_len = 2;
        push(1, 8'hE7, 1'b1);
        run_until_idle("mid_fresh", 200);
        chk("mid_fresh_ord", {nord[7:0], ord[0][7:0]}, 32'h0101);
        chk("mid_fresh_rx", {24'd0, rsp_dat[0]}, 32'h7E);

        // slow engine: busy rises 7 cycles after eng_start
        do_reset();
        eng_delay = 6;
        push(0, 8'h3A, 1'b1);
        run_until_idle("slow", 200);
        chk("slow_start_cycles", start_cnt, 8);
        chk("slow_ready", nready[0], 1);
        chk("slow_accepts", eng_accepts, 1);
        chk("slow_rx", {24'd0, rsp_dat[0]}, 32'hA3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/spi_byte_arbiter.md
SPI_BYTE_ARBITER -- requirements
Module: spi_byte_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of requesters (legal range 2..4).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  NUM_REQ  per-requester byte available.
REQ-005 SHALL have port req_data  input  8*NUM_REQ  per-requester TX byte; requester i uses bits [8i+7:8i].
REQ-006 SHALL have port req_last  input  NUM_REQ  per-requester: this byte ends the transaction.
REQ-007 SHALL have port req_ready  output  NUM_REQ  one-cycle pulse: byte accepted by the engine.
REQ-008 SHALL have port rsp_valid  output  NUM_REQ  one-cycle pulse: RX byte for requester i is on rsp_data.
REQ-009 SHALL have port rsp_data  output  8  RX byte, shared across requesters.
REQ-010 SHALL have port grant  output  NUM_REQ  one-hot current owner; all zero when unowned.
REQ-011 SHALL have port eng_start  output  1  start request to the SPI byte engine.
REQ-012 SHALL have port eng_data  output  8  TX byte to the engine.
REQ-013 SHALL have port eng_busy  input  1  engine busy flag.
REQ-014 SHALL have port eng_rx  input  8  engine received byte, valid when eng_busy falls.

Function
REQ-015 SHALL implement the states ARB, ISSUE and WAIT.
REQ-016 In ARB, with grant all zero: when any req_valid bit is high, SHALL select the first asserted requester searching upward from rr_ptr with wrap-around, set grant one-hot, and enter ISSUE on the next cycle.
REQ-017 In ISSUE: eng_start SHALL equal req_valid[owner]; eng_data SHALL equal the owner's req_data; both are combinational from state and grant.
REQ-018 In ISSUE, on eng_busy=1: SHALL pulse req_ready[owner] for exactly one cycle, latch the owner's req_last into last_q, and enter WAIT.
REQ-019 In WAIT: eng_start SHALL be 0.
REQ-020 In WAIT, on eng_busy=0: SHALL register eng_rx into rsp_data, pulse rsp_valid[owner] for one cycle, and transition as follows:
- last_q=1 -> ARB, grant cleared, rr_ptr = owner+1 mod NUM_REQ.
- last_q=0 -> ISSUE, grant kept.
REQ-021 While in ISSUE with req_valid[owner]=0, SHALL hold the grant indefinitely; other requesters SHALL NOT preempt a transaction.
REQ-022 Requesters SHALL hold req_valid, req_data and req_last stable until their req_ready pulse; the arbiter reads them only while granted.
REQ-023 Requesters not granted SHALL see req_ready=0 and rsp_valid=0 at all times.
REQ-024 Simultaneous requests in ARB SHALL be resolved solely by rr_ptr order; no fixed priority.
REQ-025 eng_start SHALL be 0 whenever grant is all zero.
REQ-026 At most one bit of req_ready, rsp_valid and grant SHALL be high in any cycle.
REQ-027 Arbitration latency SHALL be one cycle from req_valid sampled high in ARB to grant asserted.
REQ-028 A byte's rsp_valid pulse SHALL follow its req_ready pulse before the next req_ready pulse of any requester.
REQ-029 Deassertion of req_valid by a non-owner SHALL have no effect.
REQ-030 Deassertion of req_valid[owner] while in WAIT SHALL have no effect on the byte in flight.

Reset
REQ-031 On reset=1, SHALL enter ARB and clear to zero: grant, req_ready, rsp_valid, rsp_data, eng_start, rr_ptr and last_q.
REQ-032 Reset SHALL take priority over every transition, including mid-WAIT; any byte in flight is abandoned and no rsp_valid is produced for it.

Verification
REQ-033 Single byte: req0 sends 0xA5 with last=1; engine echoes 0x3C -> one req_ready[0] pulse, one rsp_valid[0] pulse with rsp_data=0x3C, grant returns to 0, rr_ptr=1.
REQ-034 Simultaneous requests: req_valid=2'b11 after reset -> req0 served first, then req1; a second simultaneous round serves req1 then req0.
REQ-035 Locked multi-byte transaction: req0 sends 3 bytes (0x9F, 0x00, 0x00 with last on the third) while req1 is asserted throughout -> grant stays 2'b01 for all 3 bytes and req1 is granted only after the third rsp_valid.
REQ-036 Stall: req0 drops req_valid for 20 cycles between bytes -> grant held, eng_start=0 during the gap, no grant to req1.
REQ-037 Reset mid-operation: reset asserted while in WAIT -> next cycle all outputs zero, no rsp_valid for the abandoned byte, and a fresh request is arbitrated normally.
REQ-038 Slow engine: eng_busy rises 7 cycles after eng_start -> exactly one req_ready pulse, eng_start held high throughout, no duplicate byte.
